// File: rtl/mux_rr_lib.sv
// mux_rr_lib: registered N-channel W-bit mux with valid/ready handshake.
// Ports: clk, rst (sync, active-high); i_data/i_valid/i_ready per channel;
//   mode (0 = select by s, 1 = round-robin), s; o_data/o_chan/o_valid/o_ready.
module mux_rr_lib #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       i_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          s,
    output logic [WIDTH-1:0]          o_data,
    output logic [SEL_W-1:0]          o_chan,
    output logic                      o_valid,
    input  logic                      o_ready
);

    localparam int NSEL = 2 ** SEL_W;
    localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Padded to the full select range so any s/idx value indexes safely;
    // missing channels read as never valid.
    logic [NSEL-1:0]  vld_ext;
    logic [WIDTH-1:0] din [NSEL];

    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic [SEL_W:0]   idx;
    logic             load_en;
    logic             take;
    logic [SEL_W-1:0] ptr_nxt;

    always_comb begin
        vld_ext = '0;
        vld_ext[CHANNELS-1:0] = i_valid;
        for (int k = 0; k < NSEL; k++) begin
            din[k] = '0;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            din[k] = i_data[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin scan runs from the farthest offset down to ptr itself,
    // so the last hit written is the first valid channel at or after ptr.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        if (mode) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                idx = {1'b0, ptr_q} + (SEL_W + 1)'(i);
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (vld_ext[idx[SEL_W-1:0]]) begin
                    gnt     = idx[SEL_W-1:0];
                    gnt_vld = 1'b1;
                end
            end
        end else if (({1'b0, s} < NCH) && vld_ext[s]) begin
            gnt     = s;
            gnt_vld = 1'b1;
        end
    end

    assign load_en = !valid_q || o_ready;
    assign take    = load_en && gnt_vld && !rst;
    assign ptr_nxt = (gnt == LAST) ? '0 : gnt + 1'b1;

    always_comb begin
        i_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            i_ready[k] = take && (gnt == SEL_W'(k));
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (gnt_vld) begin
                data_d  = din[gnt];
                chan_d  = gnt;
                valid_d = 1'b1;
                if (mode) begin
                    ptr_d = ptr_nxt;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_data  = data_q;
    assign o_chan  = chan_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_lib.sv
// tb_mux_rr_lib: scoreboard bench for mux_rr_lib, 4-channel and 3-channel
// instances driven side by side against a queue-based reference model.
module tb_mux_rr_lib;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] dat  [2][4];
    logic [3:0] vld  [2];
    logic       md   [2];
    logic [1:0] sel  [2];
    logic       ordy [2];

    logic [31:0] id0;
    logic [23:0] id1;
    logic [3:0]  ir0;
    logic [2:0]  ir1;
    logic [7:0]  od0, od1;
    logic [1:0]  oc0, oc1;
    logic        ov0, ov1;

    assign id0 = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
    assign id1 = {dat[1][2], dat[1][1], dat[1][0]};

    mux_rr_lib #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .i_data(id0), .i_valid(vld[0]),
        .i_ready(ir0), .mode(md[0]), .s(sel[0]), .o_data(od0),
        .o_chan(oc0), .o_valid(ov0), .o_ready(ordy[0])
    );

    mux_rr_lib #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .i_data(id1), .i_valid(vld[1][2:0]),
        .i_ready(ir1), .mode(md[1]), .s(sel[1]), .o_data(od1),
        .o_chan(oc1), .o_valid(ov1), .o_ready(ordy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: output occupied, rr pointer, last loaded word.
    bit         mv    [2];
    int         mptr  [2];
    logic [9:0] mhold [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
        end
    endtask

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic eval(int d);
        int         n;
        int         g;
        logic [3:0] er;
        logic [3:0] ar;
        bit         load;
        logic [9:0] w;
        n    = nch(d);
        g    = -1;
        ar   = (d == 0) ? ir0 : {1'b0, ir1};
        load = !mv[d] || ordy[d];
        if (rst) begin
            chk("i_ready_in_reset", d, 32'(ar), 32'd0);
            mv[d]    = 1'b0;
            mptr[d]  = 0;
            mhold[d] = '0;
            if (d == 0) q0.delete();
            else q1.delete();
            return;
        end
        if (!md[d]) begin
            if (int'(sel[d]) < n && vld[d][sel[d]]) g = int'(sel[d]);
        end else begin
            for (int i = 0; i < n; i++) begin
                int k;
                k = (mptr[d] + i) % n;
                if (vld[d][k]) begin
                    g = k;
                    break;
                end
            end
        end
        er = (load && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("i_ready", d, 32'(ar), 32'(er));
        if (load) begin
            if (g >= 0) begin
                w = {dat[d][g], 2'(g)};
                if (d == 0) q0.push_back(w);
                else q1.push_back(w);
                mhold[d] = w;
                mv[d]    = 1'b1;
                if (md[d]) mptr[d] = (g + 1) % n;
            end else begin
                mv[d] = 1'b0;
            end
        end
    endtask

    task automatic mon(int d);
        logic       ov;
        logic [9:0] act;
        logic [9:0] exp;
        int         sz;
        ov  = (d == 0) ? ov0 : ov1;
        act = (d == 0) ? {od0, oc0} : {od1, oc1};
        sz  = (d == 0) ? q0.size() : q1.size();
        chk("o_valid", d, 32'(ov), 32'(mv[d]));
        if (mv[d]) begin
            if (sz == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL word dut%0d: got %0h, expected nothing queued", d, act);
            end else begin
                exp = (d == 0) ? q0[0] : q1[0];
                chk("word{data,chan}", d, 32'(act), 32'(exp));
                if (ordy[d]) begin
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end else begin
            chk("hold{data,chan}", d, 32'(act), 32'(mhold[d]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        eval(0);
        eval(1);
        @(posedge clk);
        #1;
    endtask

    task automatic set(int d, logic m, logic [1:0] s_, logic [3:0] v, logic r);
        md[d]   = m;
        sel[d]  = s_;
        vld[d]  = v;
        ordy[d] = r;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mv[d]    = 1'b0;
            mptr[d]  = 0;
            mhold[d] = '0;
            for (int k = 0; k < 4; k++) dat[d][k] = 8'($urandom);
        end
        rst = 1'b1;
        set(0, 1'b1, 2'd0, 4'b1111, 1'b1);
        set(1, 1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (3) tick();

        rst = 1'b0;
        set(1, 1'b0, 2'd3, 4'b1111, 1'b1);
        repeat (8) tick();

        set(0, 1'b0, 2'd2, 4'b0100, 1'b1);
        dat[0][2] = 8'hA5;
        tick();
        sel[0] = 2'd1;
        tick();

        set(1, 1'b1, 2'd3, 4'b1111, 1'b1);
        set(0, 1'b1, 2'd0, 4'b1001, 1'b1);
        repeat (4) tick();

        set(0, 1'b0, 2'd1, 4'b0010, 1'b1);
        dat[0][1] = 8'h3C;
        tick();
        set(0, 1'b0, 2'd2, 4'b0100, 1'b0);
        dat[0][2] = 8'h5A;
        repeat (3) tick();
        ordy[0] = 1'b1;
        tick();
        vld[0] = 4'b0000;
        tick();

        set(0, 1'b1, 2'd0, 4'b0100, 1'b1);
        tick();
        set(0, 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        rst = 1'b1;
        vld[0] = 4'b1111;
        tick();
        rst = 1'b0;
        ordy[0] = 1'b1;
        repeat (2) tick();

        repeat (800) begin
            for (int d = 0; d < 2; d++) begin
                set(d, 1'($urandom), 2'($urandom), 4'($urandom),
                    1'(($urandom % 4) != 0));
                for (int k = 0; k < 4; k++) dat[d][k] = 8'($urandom);
            end
            rst = 1'(($urandom % 64) == 0);
            tick();
        end
        rst = 1'b0;

        set(0, 1'b1, 2'd0, 4'b0000, 1'b1);
        set(1, 1'b1, 2'd0, 4'b0000, 1'b1);
        repeat (3) tick();
        chk("drain_q", 0, 32'(q0.size()), 32'd0);
        chk("drain_q", 1, 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
